mem_arbiter: RTL and testbench

//  Shares the core's single memory port between two requesters: core (fetch/load/store from control FSM)
//  and debug module (system-bus access). Fair 2-way round-robin; a grant is locked until the transaction

---
 rtl/mem_arb_pkg.sv | 35 +++
 rtl/mem_arb_mux.sv | 42 ++++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory-port arbiter: FSM states,
// requester identities, the forwarded request bundle and the tie-break rule.
package mem_arb_pkg;

    localparam int BUS_ADDR_WIDTH = 32;
    localparam int BUS_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY_CORE = 2'd1,
        BUSY_DBG  = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } requester_t;

    typedef struct packed {
        logic                      read;
        logic                      write;
        logic [BUS_ADDR_WIDTH-1:0] addr;
        logic [BUS_DATA_WIDTH-1:0] wdata;
        logic [2:0]                f3;
    } mem_req_t;

    // A lone requester always wins; on a tie the side that did not finish last wins.
    function automatic requester_t rr_pick(input logic core_req, input logic dbg_req,
                                           input logic last_dbg);
        if (core_req && dbg_req) return last_dbg ? REQ_CORE : REQ_DBG;
        if (dbg_req)             return REQ_DBG;
        return REQ_CORE;
    endfunction

endpackage

// File: rtl/mem_arb_mux.sv
// Combinational steering between the two requesters and the memory port:
// forwards the selected request and routes read data / completion back to it.
module mem_arb_mux
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = BUS_DATA_WIDTH
) (
    input  requester_t            sel,
    input  logic                  active,
    input  mem_req_t              core_req,
    input  mem_req_t              dbg_req,
    output mem_req_t              fwd_req,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_complete,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  core_complete,
    output logic                  dbg_complete
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the block infers a latch.
        fwd_req       = '0;
        core_rdata    = '0;
        dbg_rdata     = '0;
        core_complete = 1'b0;
        dbg_complete  = 1'b0;
        if (active) begin
            if (sel == REQ_DBG) begin
                fwd_req      = dbg_req;
                dbg_rdata    = mem_rdata;
                dbg_complete = mem_complete;
            end else begin
                fwd_req       = core_req;
                core_rdata    = mem_rdata;
                core_complete = mem_complete;
            end
            fwd_req.read = fwd_req.read & ~fwd_req.write;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the core and the debug module;
// a grant stays locked to its owner until the transaction completes or is withdrawn.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
    parameter int DATA_WIDTH = BUS_DATA_WIDTH,
    parameter int FIRST_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_read,
    input  logic                  core_write,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    input  logic [2:0]            core_f3,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_complete,
    input  logic                  dbg_read,
    input  logic                  dbg_write,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    input  logic [2:0]            dbg_f3,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  dbg_complete,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [2:0]            mem_f3,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_complete,
    output logic                  gnt_dbg
);

    arb_state_t state;
    logic       last_dbg;
    logic       core_req;
    logic       dbg_req;
    logic       active;
    requester_t sel;
    mem_req_t   core_bus;
    mem_req_t   dbg_bus;
    mem_req_t   fwd_bus;

    assign core_req = core_read | core_write;
    assign dbg_req  = dbg_read | dbg_write;

    // Request bundles are sized by the package bus widths; wider ports get truncated.
    assign core_bus = '{read: core_read, write: core_write,
                        addr: BUS_ADDR_WIDTH'(core_addr),
                        wdata: BUS_DATA_WIDTH'(core_wdata), f3: core_f3};
    assign dbg_bus  = '{read: dbg_read, write: dbg_write,
                        addr: BUS_ADDR_WIDTH'(dbg_addr),
                        wdata: BUS_DATA_WIDTH'(dbg_wdata), f3: dbg_f3};

    // In BUSY the owner is forwarded only while it keeps its request up.
    always_comb begin
        sel    = REQ_CORE;
        active = 1'b0;
        case (state)
            IDLE: begin
                sel    = rr_pick(core_req, dbg_req, last_dbg);
                active = core_req | dbg_req;
            end
            BUSY_CORE: begin
                sel    = REQ_CORE;
                active = core_req;
            end
            BUSY_DBG: begin
                sel    = REQ_DBG;
                active = dbg_req;
            end
            default: ;
        endcase
        if (rst) active = 1'b0;
    end

    mem_arb_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux (
        .sel           (sel),
        .active        (active),
        .core_req      (core_bus),
        .dbg_req       (dbg_bus),
        .fwd_req       (fwd_bus),
        .mem_rdata     (mem_rdata),
        .mem_complete  (mem_complete),
        .core_rdata    (core_rdata),
        .dbg_rdata     (dbg_rdata),
        .core_complete (core_complete),
        .dbg_complete  (dbg_complete)
    );

    assign mem_read  = fwd_bus.read;
    assign mem_write = fwd_bus.write;
    assign mem_addr  = ADDR_WIDTH'(fwd_bus.addr);
    assign mem_wdata = DATA_WIDTH'(fwd_bus.wdata);
    assign mem_f3    = fwd_bus.f3;

    assign gnt_dbg = !rst && ((state == BUSY_DBG) || (state == IDLE && active && sel == REQ_DBG));

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state    <= IDLE;
            last_dbg <= (FIRST_PRIO == 0);
        end else begin
            case (state)
                IDLE: begin
                    if (active) begin
                        if (mem_complete) last_dbg <= (sel == REQ_DBG);
                        else              state    <= (sel == REQ_DBG) ? BUSY_DBG : BUSY_CORE;
                    end
                end
                BUSY_CORE, BUSY_DBG: begin
                    if (!active) begin
                        state <= IDLE;
                    end else if (mem_complete) begin
                        state    <= IDLE;
                        last_dbg <= (sel == REQ_DBG);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a latency-programmable memory model plus a
// scoreboard of expected completions (owner and read data) in grant order.
module tb_mem_arbiter;

    localparam logic [31:0] K  = 32'hA5A5_0000;
    localparam logic [31:0] CA = 32'h0000_1000;
    localparam logic [31:0] DA = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_read, core_write, dbg_read, dbg_write;
    logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
    logic [2:0]  core_f3, dbg_f3;
    logic [31:0] core_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        core_complete, dbg_complete, mem_read, mem_write, mem_complete, gnt_dbg;
    logic [2:0]  mem_f3;

    typedef struct {
        bit          is_dbg;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   lat   = 1;
    int   cnt;
    logic mem_force = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIRST_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .core_read(core_read), .core_write(core_write), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_f3(core_f3), .core_rdata(core_rdata),
        .core_complete(core_complete),
        .dbg_read(dbg_read), .dbg_write(dbg_write), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_f3(dbg_f3), .dbg_rdata(dbg_rdata),
        .dbg_complete(dbg_complete),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_f3(mem_f3), .mem_rdata(mem_rdata),
        .mem_complete(mem_complete), .gnt_dbg(gnt_dbg)
    );

    // Memory model: completes after lat cycles of continuous request; data = addr ^ K.
    assign mem_complete = ((mem_read || mem_write) && (cnt == lat - 1)) || mem_force;
    assign mem_rdata    = mem_addr ^ K;

    always @(posedge clk) begin
        if (rst || !(mem_read || mem_write) || mem_complete) cnt <= 0;
        else                                                 cnt <= cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push(input bit is_dbg, input logic [31:0] addr);
        sb.push_back('{is_dbg, addr ^ K});
    endtask

    always @(negedge clk) begin
        if (core_complete || dbg_complete) begin
            chk("sb_both", core_complete & dbg_complete, 0);
            chk("sb_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("sb_owner", dbg_complete, mon_e.is_dbg);
                chk("sb_rdata", dbg_complete ? dbg_rdata : core_rdata, mon_e.rdata);
                chk("sb_other_rdata", dbg_complete ? core_rdata : dbg_rdata, 0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        core_read = 0; core_write = 0; core_addr = '0; core_wdata = '0; core_f3 = '0;
        dbg_read  = 0; dbg_write  = 0; dbg_addr  = '0; dbg_wdata  = '0; dbg_f3  = '0;

        // Reset cycle with live requests: everything must stay quiet.
        tick();
        core_read = 1; core_addr = CA; dbg_write = 1; dbg_addr = DA;
        sample();
        chk("rst_mem_rw", {mem_read, mem_write}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_gnt", gnt_dbg, 0);
        chk("rst_complete", {core_complete, dbg_complete}, 0);

        tick();
        rst = 0; core_read = 0; dbg_write = 0;
        sample();
        chk("idle_no_req", {mem_read, mem_write}, 0);
        chk("idle_addr", mem_addr, 0);

        // Single-cycle core read.
        tick();
        core_read = 1; core_addr = 32'hB791_5678; core_f3 = 3'd2;
        push(0, core_addr);
        sample();
        chk("t1_complete", core_complete, 1);
        chk("t1_rdata", core_rdata, 32'h1234_5678);
        chk("t1_dbg_complete", dbg_complete, 0);
        chk("t1_f3", mem_f3, 3'd2);
        tick();
        core_read = 0;
        sample();
        chk("t1_idle_after", mem_read, 0);

        // Tie after reset, 3-cycle memory: core first, then debug.
        tick();
        rst = 1;
        sample();
        tick();
        rst = 0; lat = 3;
        core_read = 1; core_addr = CA; dbg_read = 1; dbg_addr = DA;
        push(0, CA); push(1, DA);
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) begin
                tick();
                if (c == 4) core_read = 0;
            end
            sample();
            chk($sformatf("t2_gnt_c%0d", c), gnt_dbg, c >= 4);
            chk($sformatf("t2_addr_c%0d", c), mem_addr, (c <= 3) ? CA : DA);
            chk($sformatf("t2_core_done_c%0d", c), core_complete, c == 3);
            chk($sformatf("t2_dbg_done_c%0d", c), dbg_complete, c == 6);
        end
        tick();
        dbg_read = 0;
        sample();

        // Both held continuously with 1-cycle memory: strict alternation.
        lat = 1;
        for (int i = 0; i < 8; i++) push(i % 2 == 1, (i % 2 == 1) ? DA : CA);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) begin
                core_read = 1; dbg_read = 1;
            end
            sample();
            chk($sformatf("t3_gnt_%0d", i), gnt_dbg, i % 2);
            chk($sformatf("t3_addr_%0d", i), mem_addr, (i % 2 == 1) ? DA : CA);
        end
        tick();
        core_read = 0; dbg_read = 0;
        lat = 3;
        sample();

        // Debug write (read also raised) arriving while core owns the port.
        push(0, CA); push(1, 32'h100);
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 1) begin
                core_read = 1; core_addr = CA;
            end
            if (c == 2) begin
                dbg_write = 1; dbg_read = 1; dbg_addr = 32'h100;
                dbg_wdata = 32'hDEAD_BEEF; dbg_f3 = 3'd2;
            end
            if (c == 4) core_read = 0;
            sample();
            if (c <= 3) begin
                chk($sformatf("t4_core_addr_c%0d", c), mem_addr, CA);
                chk($sformatf("t4_core_rw_c%0d", c), {mem_read, mem_write}, 2'b10);
                chk($sformatf("t4_dbg_wait_c%0d", c), dbg_complete, 0);
            end else begin
                chk($sformatf("t4_dbg_addr_c%0d", c), mem_addr, 32'h100);
                chk($sformatf("t4_dbg_rw_c%0d", c), {mem_read, mem_write}, 2'b01);
                chk($sformatf("t4_dbg_wdata_c%0d", c), mem_wdata, 32'hDEAD_BEEF);
                chk($sformatf("t4_dbg_f3_c%0d", c), mem_f3, 3'd2);
            end
        end
        tick();
        dbg_write = 0; dbg_read = 0; dbg_wdata = '0; dbg_f3 = '0;
        sample();

        // Core withdraws mid-transaction; debug waits, then is granted from IDLE.
        lat = 10;
        tick();
        core_read = 1; core_addr = CA;
        sample();
        chk("t5_core_fwd", mem_read, 1);
        tick();
        core_read = 0; dbg_read = 1; dbg_addr = DA;
        sample();
        chk("t5_drop_read", mem_read, 0);
        chk("t5_drop_addr", mem_addr, 0);
        chk("t5_no_complete", core_complete, 0);
        chk("t5_dbg_stalled", gnt_dbg, 0);
        tick();
        sample();
        chk("t5_idle_next_gnt", gnt_dbg, 1);
        chk("t5_idle_next_addr", mem_addr, DA);
        tick();
        sample();
        chk("t6_busy_dbg", gnt_dbg, 1);

        // Reset in the middle of a debug transaction.
        tick();
        rst = 1; core_read = 1; core_addr = CA;
        sample();
        chk("t6_rst_rw", {mem_read, mem_write}, 0);
        chk("t6_rst_addr", mem_addr, 0);
        chk("t6_rst_gnt", gnt_dbg, 0);
        chk("t6_rst_complete", {core_complete, dbg_complete}, 0);
        chk("t6_rst_rdata", dbg_rdata, 0);
        tick();
        rst = 0; lat = 1;
        push(0, CA);
        sample();
        chk("t6_tie_gnt", gnt_dbg, 0);
        chk("t6_tie_addr", mem_addr, CA);
        tick();
        core_read = 0;
        push(1, DA);
        sample();
        chk("t6_dbg_next", gnt_dbg, 1);

        // Stray completion with nothing forwarded is ignored.
        tick();
        dbg_read = 0; mem_force = 1;
        sample();
        chk("t7_stray_complete", {core_complete, dbg_complete}, 0);
        tick();
        mem_force = 0;
        sample();
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
